// File: rtl/ps2_scan_rx_if.sv
// ps2_scan_rx_if: PS/2 line inputs and decoded key event outputs (master drives lines, slave decodes).
interface ps2_scan_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       key_valid;
  logic       parity_err;
  logic       frame_err;
  modport master (
    output ps2_clk, ps2_data,
    input  key_code, key_break, key_ext, key_valid, parity_err, frame_err
  );
  modport slave (
    input  ps2_clk, ps2_data,
    output key_code, key_break, key_ext, key_valid, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 frame receiver and E0/F0 scan code decoder; clk/reset plus bus (ps2 lines in, key event pulses out).
module ps2_scan_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic           clk,
  input logic           reset,
  ps2_scan_rx_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic [1:0] state;
  logic ps2_clk_q;
  logic [2:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0] shift;
  logic par;
  logic ext_pend;
  logic brk_pend;
  logic fall;
  logic timeout;
  assign fall = ps2_clk_q & ~bus.ps2_clk;
  // a falling edge in the expiry cycle restarts the window instead of timing out
  assign timeout = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ps2_clk_q      <= 1'b1;
      bit_cnt        <= '0;
      to_cnt         <= '0;
      shift          <= '0;
      par            <= 1'b0;
      ext_pend       <= 1'b0;
      brk_pend       <= 1'b0;
      bus.key_code   <= '0;
      bus.key_break  <= 1'b0;
      bus.key_ext    <= 1'b0;
      bus.key_valid  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      ps2_clk_q      <= bus.ps2_clk;
      bus.key_valid  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      to_cnt         <= (fall || state == IDLE) ? '0 : to_cnt + 1'b1;
      if (timeout) begin
        state         <= IDLE;
        bus.frame_err <= 1'b1;
        ext_pend      <= 1'b0;
        brk_pend      <= 1'b0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!bus.ps2_data) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              bus.frame_err <= 1'b1;
              ext_pend      <= 1'b0;
              brk_pend      <= 1'b0;
            end
          end
          DATA: begin
            shift[bit_cnt] <= bus.ps2_data;
            bit_cnt        <= bit_cnt + 1'b1;
            state          <= (bit_cnt == 3'd7) ? PARITY : DATA;
          end
          PARITY: begin
            par   <= bus.ps2_data;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            if (!bus.ps2_data) begin
              bus.frame_err <= 1'b1;
              ext_pend      <= 1'b0;
              brk_pend      <= 1'b0;
            end else if (!(^{shift, par})) begin
              bus.parity_err <= 1'b1;
              ext_pend       <= 1'b0;
              brk_pend       <= 1'b0;
            end else if (shift == 8'hE0) begin
              ext_pend <= 1'b1;
            end else if (shift == 8'hF0) begin
              brk_pend <= 1'b1;
            end else begin
              bus.key_code  <= shift;
              bus.key_break <= brk_pend;
              bus.key_ext   <= ext_pend;
              bus.key_valid <= 1'b1;
              ext_pend      <= 1'b0;
              brk_pend      <= 1'b0;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

Receives PS/2 keyboard frames from the debounced `ps2_clk`/`ps2_data` lines and decodes them into key events. It checks frame structure, odd parity and inter-bit timeout, and handles the `E0` extended prefix and the `F0` break prefix. Each decoded key is emitted as a single-cycle `key_valid` pulse. It sits directly downstream of the two debouncers on the PS/2 pins and feeds the keyboard command logic.

## Interface
- `TIMEOUT_CYCLES`, default 50000: maximum `clk` cycles between `ps2_clk` falling edges inside a frame (1 ms at 50 MHz). Must be ≥ 2. Counter width is `$clog2(TIMEOUT_CYCLES)`.

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `ps2_clk`  in  1  debounced PS/2 clock, synchronous to `clk`
- `ps2_data`  in  1  debounced PS/2 data, synchronous to `clk`
- `key_code`  out  8  scan code of the last decoded key; held until the next `key_valid`
- `key_break`  out  1  last key was a release (`F0` prefix seen)
- `key_ext`  out  1  last key was extended (`E0` prefix seen)
- `key_valid`  out  1  one-cycle pulse; `key_code`, `key_break` and `key_ext` are new on this cycle
- `parity_err`  out  1  one-cycle pulse on a frame rejected for parity
- `frame_err`  out  1  one-cycle pulse on a bad start bit, bad stop bit or timeout

## Operation
- **Edge detect:** `ps2_clk_q` is the registered `ps2_clk`, reset value 1. `fall = ps2_clk_q & ~ps2_clk`. `ps2_data` is sampled in the same cycle that `fall` is true.
- **Frame states:** IDLE, DATA, PARITY, STOP.
  - IDLE, on `fall`:
    - data = 0: go to DATA, clear `bit_cnt`.
    - data = 1: pulse `frame_err`, stay in IDLE.
  - DATA, on `fall`: store data into `shift[bit_cnt]` (LSB first) and increment `bit_cnt`. After the 8th bit, go to PARITY.
  - PARITY, on `fall`: store the parity bit, go to STOP.
  - STOP, on `fall`: always go to IDLE, then evaluate in this order:
    - stop bit = 0: `frame_err`.
    - else, XOR of the 8 data bits and the parity bit = 0: `parity_err`.
    - else: the byte is accepted.
- **Timeout:** `to_cnt` clears on every `fall` and while in IDLE, and increments otherwise. If it reaches `TIMEOUT_CYCLES-1` outside IDLE: go to IDLE, pulse `frame_err`, discard the partial byte.
- **Byte decode** (accepted bytes only):
  - `E0`: set `ext_pend`, no output.
  - `F0`: set `brk_pend`, no output.
  - Any other value:
    - `key_code` ← byte.
    - `key_break` ← `brk_pend`.
    - `key_ext` ← `ext_pend`.
    - Pulse `key_valid`.
    - Clear both pending flags.
- **Errors:** any `frame_err` or `parity_err` clears `ext_pend` and `brk_pend`.

## Timing
- **Reset values:**
  - All outputs 0.
  - State IDLE; `bit_cnt`, `to_cnt`, `shift`, `ext_pend`, `brk_pend` all 0.
  - `ps2_clk_q` = 1.
- **Latency:** if the stop-bit `fall` occurs in cycle N, then `key_valid`, `parity_err` or `frame_err` is high in cycle N+1 only. Data outputs change in cycle N+1.
- **Prefix bytes** produce no pulse on any output.
- **Timeout and `fall` in the same cycle:** `fall` wins, the counter clears and no timeout occurs.
- **Reset mid-frame:** takes effect on the next edge of `clk`. The partial frame is lost, pending flags clear and no pulse is produced.
- **Outputs:** all registered; there is no combinational path from inputs to outputs.
- **`ps2_clk` held high while in IDLE:** no activity and no timeout.

## Test plan
All frames are driven with at least 2000 `clk` cycles per PS/2 half-period.

1. Frame `1C`: start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1 → one `key_valid` pulse, `key_code` = `1C`, `key_break` = 0, `key_ext` = 0. Pulse occurs 1 cycle after the stop-bit fall.
2. Frames `F0`, `1C` → exactly one `key_valid`, `key_code` = `1C`, `key_break` = 1, `key_ext` = 0. No pulse after `F0`.
3. Frames `E0`, `F0`, `75` → one `key_valid`, `key_code` = `75`, `key_ext` = 1, `key_break` = 1. A following plain `75` frame gives both flags = 0.
4. Frame `F0`, then `1C` with parity 1 → `parity_err` pulse and no `key_valid`. A following good `1C` gives `key_break` = 0. A good frame with stop = 0 gives a `frame_err` pulse and no `key_valid`.
5. Start bit plus 4 data bits, then `ps2_clk` held high for `TIMEOUT_CYCLES` + 10 cycles → one `frame_err` pulse at timeout. A subsequent full `29` frame decodes to `key_code` = `29`.
6. `reset` pulsed for 1 cycle after 5 data bits of a frame → all outputs 0 and no pulses. A following `5A` frame decodes correctly with `key_break` = 0 and `key_ext` = 0.
